// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU
// and their *W variants. Single entry, valid/ready on both sides, flushable.
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), async active-low reset
//   valid_i / ready_o     operation handshake (ready_o high only in IDLE)
//   op_i                  bit0 = unsigned, bit1 = remainder
//   word_i                *W variant (low 32 bits, result sign-extended)
//   rs1_i, rs2_i, rd_i    dividend, divisor, destination tag
//   flush_i               abort any in-flight or pending operation
//   valid_o / ready_i     result handshake
//   result_o, rd_o        quotient or remainder, returned tag
//
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when
// |dividend| < |divisor| (non-zero divisor).
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o
);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0] dvd_q;      // dividend shifts out, quotient shifts in
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dsr_q;      // divisor magnitude
  logic [6:0]      cnt_q;
  logic            rem_sel_q, word_q, neg_q_q, neg_r_q;

  logic            accept;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b, min_neg, special_res;
  logic            sign_a, sign_b, div_zero, ovf, early, special;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] diff, q_signed, r_signed;
  logic            ge;

  function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] v, input logic w);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign accept = valid_i && (state_q == IDLE) && !flush_i;

  // Operand preparation and one-cycle special cases.
  always_comb begin
    a_ext = rs1_i;
    b_ext = rs2_i;
    if (word_i) begin
      a_ext = op_i[0] ? {{(XLEN-32){1'b0}}, rs1_i[31:0]} : {{(XLEN-32){rs1_i[31]}}, rs1_i[31:0]};
      b_ext = op_i[0] ? {{(XLEN-32){1'b0}}, rs2_i[31:0]} : {{(XLEN-32){rs2_i[31]}}, rs2_i[31:0]};
    end
    sign_a   = !op_i[0] && a_ext[XLEN-1];
    sign_b   = !op_i[0] && b_ext[XLEN-1];
    mag_a    = sign_a ? -a_ext : a_ext;
    mag_b    = sign_b ? -b_ext : b_ext;
    min_neg  = word_i ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (b_ext == '0);
    ovf      = !op_i[0] && (a_ext == min_neg) && (b_ext == '1);
`ifdef DIV_EARLY_OUT_EN
    early    = !div_zero && (mag_a < mag_b);
`else
    early    = 1'b0;
`endif
    special  = div_zero || ovf || early;
    if (div_zero)
      special_res = op_i[1] ? a_ext : '1;
    else if (ovf)
      special_res = op_i[1] ? '0 : a_ext;
    else
      special_res = op_i[1] ? a_ext : '0;
    special_res = wext(special_res, word_i);
  end

  // One restoring step; the remainder always fits XLEN bits after the
  // subtract, so the difference is taken modulo 2^XLEN.
  always_comb begin
    trial    = {rem_q, dvd_q[XLEN-1]};
    ge       = (trial >= {1'b0, dsr_q});
    diff     = trial[XLEN-1:0] - dsr_q;
    q_signed = neg_q_q ? -dvd_q : dvd_q;
    r_signed = neg_r_q ? -rem_q : rem_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_o = 1'b1;
        if (accept) state_d = special ? DONE : ITER;
      end
      ITER:  if (cnt_q == 7'd1) state_d = FIXUP;
      FIXUP: state_d = DONE;
      DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      word_q    <= 1'b0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      result_o  <= '0;
      rd_o      <= '0;
    end else if (accept) begin
      rd_o      <= rd_i;
      rem_sel_q <= op_i[1];
      word_q    <= word_i;
      neg_q_q   <= sign_a ^ sign_b;
      neg_r_q   <= sign_a;
      dsr_q     <= mag_b;
      rem_q     <= '0;
      // Word ops put the 32-bit magnitude at the top so 32 steps suffice.
      dvd_q     <= word_i ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
      cnt_q     <= word_i ? 7'd32 : 7'd64;
      if (special) result_o <= special_res;
    end else if (state_q == ITER && !flush_i) begin
      dvd_q <= {dvd_q[XLEN-2:0], ge};
      rem_q <= ge ? diff : trial[XLEN-1:0];
      cnt_q <= cnt_q - 7'd1;
    end else if (state_q == FIXUP && !flush_i) begin
      result_o <= wext(rem_sel_q ? r_signed : q_signed, word_q);
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Table of hand-derived
// vectors, hand-written handshake/flush/reset sequences and a batch of
// random operations checked against a behavioural model via a scoreboard.
module tb_div_unit;

`ifdef DIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni, valid_i, ready_o, word_i, flush_i, valid_o, ready_i;
  logic [1:0]  op_i;
  logic [63:0] rs1_i, rs2_i, result_o;
  logic [4:0]  rd_i, rd_o;

  div_unit #(.XLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .word_i(word_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o), .rd_o(rd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  rd;
    logic [63:0] exp;
    int          lat;
    bit          eo;   // qualifies for early-out when enabled
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  vec_t vecs[22];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [31:0] a32, b32, r32;
    logic [63:0] r;
    if (word) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 32'd0)                                       r32 = op[1] ? a32 : 32'hFFFF_FFFF;
      else if (!op[0] && a32 == 32'h8000_0000 && b32 == '1)   r32 = op[1] ? 32'd0 : a32;
      else if (op[0])                                         r32 = op[1] ? a32 % b32 : a32 / b32;
      else if (op[1])                                         r32 = $signed(a32) % $signed(b32);
      else                                                    r32 = $signed(a32) / $signed(b32);
      r = {{32{r32[31]}}, r32};
    end else begin
      if (b == 64'd0)                                                r = op[1] ? a : '1;
      else if (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1)    r = op[1] ? 64'd0 : a;
      else if (op[0])                                                r = op[1] ? a % b : a / b;
      else if (op[1])                                                r = $signed(a) % $signed(b);
      else                                                           r = $signed(a) / $signed(b);
    end
    return r;
  endfunction

  task automatic issue_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          input logic [63:0] exp, input bit push);
    int k = 0;
    while (!ready_o && k < 300) begin
      @(posedge clk_i); #1; k++;
    end
    chk("ready before issue", {63'd0, ready_o}, 64'd1);
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; word_i = word; rs1_i = a; rs2_i = b; rd_i = rd;
    if (push) sb.push_back('{res: exp, rd: rd});
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  // Called just after the accept edge; latency counts edges from accept to
  // the first edge at which valid_o is seen high.
  task automatic wait_result(input int exp_lat, input string name);
    int   k = 0;
    exp_t e;
    while (!valid_o && k < 200) begin
      @(posedge clk_i); #1; k++;
    end
    if (!valid_o) begin
      tests++; fails++;
      $display("FAIL %s timeout: valid_o low after %0d cycles, required high", name, k);
    end else if (sb.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s: unexpected result %h, required none", name, result_o);
    end else begin
      e = sb.pop_front();
      chk({name, " result"}, result_o, e.res);
      chk({name, " rd"}, {59'd0, rd_o}, {59'd0, e.rd});
      if (exp_lat > 0) chk({name, " latency"}, 64'(k + 1), 64'(exp_lat));
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input logic [63:0] exp,
                        input int lat, input string name);
    issue_op(op, word, a, b, rd, exp, 1'b1);
    wait_result(lat, name);
    @(posedge clk_i); #1;
    chk({name, " idle after handshake"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok, seen;
    logic [1:0]  rop;
    logic        rw;
    logic [63:0] ra, rb;

    rst_ni = 1'b0; valid_i = 1'b0; op_i = '0; word_i = 1'b0; rs1_i = '0; rs2_i = '0;
    rd_i = '0; flush_i = 1'b0; ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset ready_o",  {63'd0, ready_o}, 64'd1);
    chk("reset valid_o",  {63'd0, valid_o}, 64'd0);
    chk("reset result_o", result_o, 64'd0);
    chk("reset rd_o",     {59'd0, rd_o}, 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    vecs[0]  = '{DIVU, 1'b0, 64'd100, 64'd7, 5'd5, 64'd14, 66, 1'b0};
    vecs[1]  = '{REMU, 1'b0, 64'd100, 64'd7, 5'd6, 64'd2, 66, 1'b0};
    vecs[2]  = '{DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0};
    vecs[3]  = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd8, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0};
    vecs[4]  = '{DIV,  1'b1, 64'h0000_0001_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 64'hFFFF_FFFF_8000_0000, 1, 1'b0};
    vecs[5]  = '{DIV,  1'b0, 64'd5, 64'd0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0};
    vecs[6]  = '{REMU, 1'b0, 64'd5, 64'd0, 5'd11, 64'd5, 1, 1'b0};
    vecs[7]  = '{DIVU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0};
    vecs[8]  = '{REMU, 1'b0, 64'd3, 64'd10, 5'd13, 64'd3, 66, 1'b1};
    vecs[9]  = '{DIV,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 64'h8000_0000_0000_0000, 1, 1'b0};
    vecs[10] = '{REM,  1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 1, 1'b0};
    vecs[11] = '{REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0};
    vecs[12] = '{DIV,  1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd17, 64'hFFFF_FFFF_FFFF_FFFD, 34, 1'b0};
    vecs[13] = '{REMU, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 5'd18, 64'd1, 34, 1'b0};
    vecs[14] = '{DIV,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd19, 64'd14, 66, 1'b0};
    vecs[15] = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'hFFFF_FFFF_FFFF_FFF9, 5'd20, 64'hFFFF_FFFF_FFFF_FFFE, 66, 1'b0};
    vecs[16] = '{DIV,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd21, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1'b0};
    vecs[17] = '{REM,  1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 5'd22, 64'd2, 66, 1'b0};
    vecs[18] = '{DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd23, 64'h7FFF_FFFF_FFFF_FFFF, 66, 1'b0};
    vecs[19] = '{DIVU, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 5'd24, 64'hFFFF_FFFF_FFFF_FFFE, 34, 1'b0};
    vecs[20] = '{REM,  1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 5'd25, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b1};
    vecs[21] = '{REM,  1'b1, 64'h0000_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'd26, 64'hFFFF_FFFF_8000_0005, 1, 1'b0};

    for (int i = 0; i < 22; i++) begin
      run_op(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp,
             (vecs[i].eo && EARLY) ? 1 : vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Result held in DONE while the consumer stalls; a second request is ignored.
    ready_i = 1'b0;
    issue_op(DIVU, 1'b0, 64'd1000, 64'd10, 5'd27, 64'd100, 1'b1);
    wait_result(66, "hold");
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      valid_i = 1'b1; op_i = DIVU; word_i = 1'b0; rs1_i = 64'd50; rs2_i = 64'd5; rd_i = 5'd1;
      @(posedge clk_i); #1;
      if (!valid_o || ready_o || result_o !== 64'd100 || rd_o !== 5'd27) ok = 1'b0;
    end
    chk("hold stable", {63'd0, ok}, 64'd1);
    @(negedge clk_i);
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("release ready_o", {63'd0, ready_o}, 64'd1);
    chk("release valid_o", {63'd0, valid_o}, 64'd0);

    // Flush in the middle of ITER.
    issue_op(DIVU, 1'b0, 64'd100, 64'd7, 5'd2, 64'd0, 1'b0);
    repeat (19) @(posedge clk_i);
    @(negedge clk_i) flush_i = 1'b1;
    @(posedge clk_i); #1;
    chk("flush ready_o", {63'd0, ready_o}, 64'd1);
    chk("flush valid_o", {63'd0, valid_o}, 64'd0);
    @(negedge clk_i) flush_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("no valid after flush", {63'd0, seen}, 64'd0);
    run_op(DIVU, 1'b0, 64'd9, 64'd3, 5'd3, 64'd3, 66, "post-flush");

    // Flush together with valid_i in IDLE blocks the accept.
    @(negedge clk_i);
    valid_i = 1'b1; flush_i = 1'b1; op_i = DIVU; rs1_i = 64'd9; rs2_i = 64'd3; rd_i = 5'd4;
    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    chk("flush blocks accept", {63'd0, ready_o}, 64'd1);

    // Asynchronous reset mid-operation.
    issue_op(DIV, 1'b0, 64'd100, 64'd7, 5'd30, 64'd0, 1'b0);
    repeat (5) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("async reset ready_o",  {63'd0, ready_o}, 64'd1);
    chk("async reset valid_o",  {63'd0, valid_o}, 64'd0);
    chk("async reset result_o", result_o, 64'd0);
    chk("async reset rd_o",     {59'd0, rd_o}, 64'd0);
    @(negedge clk_i) rst_ni = 1'b1;

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      rw  = 1'($urandom_range(0, 1));
      ra  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 40)) : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       rb = 64'($urandom_range(0, 15));
        1:       rb = {$urandom, $urandom};
        2:       rb = '1;
        default: rb = {32'd0, $urandom};
      endcase
      run_op(rop, rw, ra, rb, 5'(i), model(rop, rw, ra, rb), 0, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
